// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display serializer.
package display_pkg;

    localparam int unsigned DISPLAY_DIGITS = 26;
    localparam int unsigned SEG_BITS       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } e_SerState;

endpackage

// File: rtl/display_frame_serializer_down_counter.sv
// DownCounter: loadable down counter that saturates at zero; o_last_c flags the terminal count.
module DownCounter #(
    parameter int unsigned     WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_last_c
);

    logic [WIDTH-1:0] r_count;

    // Load wins over decrement; decrement stops at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_last_c = (r_count == '0);

endmodule

// File: rtl/display_frame_serializer.sv
// Bit-serial source for the segment display shift chain with a per-frame latch pulse.
// Build option DISPLAY_SER_LSB_FIRST_EN sends each byte LSB first (default MSB first).
module display_frame_serializer
    import display_pkg::*;
#(
    parameter int unsigned BYTES_PER_FRAME = DISPLAY_DIGITS,
    parameter int unsigned BYTE_WIDTH      = SEG_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ser_out,
    output logic                  shift_en,
    output logic                  latch,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned BYTE_CNT_W = $clog2(BYTES_PER_FRAME);
    localparam int unsigned BIT_CNT_W  = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_FRAME - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LOAD  = BIT_CNT_W'(BYTE_WIDTH - 1);

    e_SerState             r_state;
    e_SerState             w_state_nxt;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [BYTE_CNT_W-1:0] w_byte_cnt_nxt;
    logic [BYTE_WIDTH-1:0] r_shreg;
    logic [BYTE_WIDTH-1:0] w_shreg_nxt;
    logic                  r_ser_out;
    logic                  w_ser_out_nxt;
    logic                  r_shift_en;
    logic                  w_shift_en_nxt;
    logic                  r_latch;
    logic                  r_frame_done;
    logic                  w_latch_nxt;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_bit_last;
    logic                  w_bit_load;
    logic                  w_bit_dec;
    logic [BYTE_WIDTH-1:0] w_src;
    logic                  w_head;
    logic [BYTE_WIDTH-1:0] w_rest;

    DownCounter #(
        .WIDTH     (BIT_CNT_W),
        .RESET_VAL (BIT_LOAD)
    ) u_bit_cnt (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_bit_load),
        .i_dec      (w_bit_dec),
        .i_load_val (BIT_LOAD),
        .o_last_c   (w_bit_last)
    );

    // Ready in IDLE, or on the final bit of a non-final byte so bytes chain without a bubble.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            IDLE:    w_in_ready = 1'b1;
            SHIFT:   w_in_ready = w_bit_last && (r_byte_cnt != LAST_BYTE);
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_accept = in_valid && w_in_ready;

    // A fresh byte is taken straight from the input so its first bit leaves one cycle after accept.
    assign w_src = w_accept ? in_data : r_shreg;
`ifdef DISPLAY_SER_LSB_FIRST_EN
    assign w_head = w_src[0];
    assign w_rest = w_src >> 1;
`else
    assign w_head = w_src[BYTE_WIDTH-1];
    assign w_rest = w_src << 1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_byte_cnt   <= '0;
            r_shreg      <= '0;
            r_ser_out    <= 1'b0;
            r_shift_en   <= 1'b0;
            r_latch      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_shreg      <= w_shreg_nxt;
            r_ser_out    <= w_ser_out_nxt;
            r_shift_en   <= w_shift_en_nxt;
            r_latch      <= w_latch_nxt;
            r_frame_done <= w_latch_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_shreg_nxt    = r_shreg;
        w_ser_out_nxt  = 1'b0;
        w_shift_en_nxt = 1'b0;
        w_latch_nxt    = 1'b0;
        w_bit_load     = 1'b0;
        w_bit_dec      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = SHIFT;
                    w_ser_out_nxt  = w_head;
                    w_shreg_nxt    = w_rest;
                    w_shift_en_nxt = 1'b1;
                    w_bit_load     = 1'b1;
                end
            end
            SHIFT: begin
                if (!w_bit_last) begin
                    w_ser_out_nxt  = w_head;
                    w_shreg_nxt    = w_rest;
                    w_shift_en_nxt = 1'b1;
                    w_bit_dec      = 1'b1;
                end else if (r_byte_cnt == LAST_BYTE) begin
                    w_state_nxt = LATCH;
                    w_latch_nxt = 1'b1;
                    w_bit_load  = 1'b1;
                end else if (w_accept) begin
                    w_byte_cnt_nxt = r_byte_cnt + BYTE_CNT_W'(1);
                    w_ser_out_nxt  = w_head;
                    w_shreg_nxt    = w_rest;
                    w_shift_en_nxt = 1'b1;
                    w_bit_load     = 1'b1;
                end else begin
                    w_state_nxt    = IDLE;
                    w_byte_cnt_nxt = r_byte_cnt + BYTE_CNT_W'(1);
                    w_bit_load     = 1'b1;
                end
            end
            LATCH: begin
                w_state_nxt    = IDLE;
                w_byte_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign in_ready   = w_in_ready;
    assign ser_out    = r_ser_out;
    assign shift_en   = r_shift_en;
    assign latch      = r_latch;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_display_frame_serializer.sv
// Scoreboard bench for display_frame_serializer: driver queues expected bits/latches, monitor pops and compares.
module tb_display_frame_serializer;

    localparam int unsigned NB = 26;
    localparam int unsigned BW = 8;

    typedef struct {
        bit is_latch;
        bit val;
        bit eob;
        bit eof;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          ser_out;
    logic          shift_en;
    logic          latch;
    logic          busy;
    logic          frame_done;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   n_shift;
    int   n_latch;
    int   frame_cnt;
    bit   prev_eof;

    display_frame_serializer #(
        .BYTES_PER_FRAME (NB),
        .BYTE_WIDTH      (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_out    (ser_out),
        .shift_en   (shift_en),
        .latch      (latch),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every latch or shift cycle must match the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_eof = 1'b0;
        end else begin
            if (latch || frame_done) begin
                chk("frame_done_vs_latch", int'(frame_done), int'(latch));
                if (sb.size() == 0) begin
                    chk("latch_unexpected", int'(latch), 0);
                end else if (!sb[0].is_latch) begin
                    chk("latch_early", int'(latch), 0);
                end else begin
                    e = sb.pop_front();
                    n_latch++;
                    chk("latch_after_last_shift", int'(prev_eof), 1);
                    chk("in_ready_in_latch", int'(in_ready), 0);
                    chk("shift_en_in_latch", int'(shift_en), 0);
                end
            end
            if (shift_en) begin
                n_shift++;
                if (sb.size() == 0) begin
                    chk("shift_unexpected", int'(shift_en), 0);
                    prev_eof = 1'b0;
                end else if (sb[0].is_latch) begin
                    chk("shift_instead_of_latch", int'(shift_en), 0);
                    prev_eof = 1'b0;
                end else begin
                    e = sb.pop_front();
                    chk("ser_out", int'(ser_out), int'(e.val));
                    chk("busy_while_shift", int'(busy), 1);
                    if (e.eob) chk("in_ready_final_bit", int'(in_ready), e.eof ? 0 : 1);
                    prev_eof = e.eof;
                end
            end else begin
                prev_eof = 1'b0;
            end
        end
    end

    task automatic push_byte(input logic [BW-1:0] d);
        exp_t e;
        frame_cnt++;
        for (int i = 0; i < int'(BW); i++) begin
`ifdef DISPLAY_SER_LSB_FIRST_EN
            e.val = d[i];
`else
            e.val = d[BW-1-i];
`endif
            e.is_latch = 1'b0;
            e.eob      = (i == int'(BW) - 1);
            e.eof      = e.eob && (frame_cnt == int'(NB));
            sb.push_back(e);
        end
        if (frame_cnt == int'(NB)) begin
            e.is_latch = 1'b1;
            e.val      = 1'b0;
            e.eob      = 1'b0;
            e.eof      = 1'b0;
            sb.push_back(e);
            frame_cnt = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [BW-1:0] d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            in_data = BW'($urandom);
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", int'(in_ready), 1);
        end else begin
            in_data = d;
            push_byte(d);
            @(posedge clk);
            @(negedge clk);
            chk("first_bit_latency", int'(shift_en), 1);
        end
        in_valid = 1'b0;
        in_data  = BW'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while ((sb.size() != 0 || busy) && guard < 400);
        if (sb.size() != 0 || busy) chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic sync_reset();
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        frame_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        n_shift = 0;
        n_latch = 0;
    endtask

    task automatic check_frame(input string nm, input int exp_shift, input int exp_latch);
        chk({nm, "_shift_count"}, n_shift, exp_shift);
        chk({nm, "_latch_count"}, n_latch, exp_latch);
        n_shift = 0;
        n_latch = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0; n_err = 0; n_shift = 0; n_latch = 0; frame_cnt = 0; prev_eof = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rst      = 1'b0;

        // Async reset asserted mid-cycle.
        #2 rst = 1'b1;
        #1;
        chk("rst_ser_out", int'(ser_out), 0);
        chk("rst_shift_en", int'(shift_en), 0);
        chk("rst_latch", int'(latch), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Single bytes: A5 then C1, no latch expected.
        @(negedge clk);
        send_byte(8'hA5);
        wait_idle();
        chk("single_in_ready", int'(in_ready), 1);
        chk("single_busy", int'(busy), 0);
        send_byte(8'hC1);
        wait_idle();
        check_frame("single", 16, 0);

        // Full back-to-back frame.
        sync_reset();
        for (int i = 0; i < int'(NB); i++) send_byte(BW'(i));
        wait_idle();
        check_frame("full", 208, 1);

        // Gapped frame: idle gap after byte 10.
        @(negedge clk);
        for (int i = 0; i < 10; i++) send_byte(BW'(8'h30 + i));
        wait_idle();
        repeat (5) @(negedge clk);
        for (int i = 10; i < int'(NB); i++) send_byte(BW'(8'h30 + i));
        wait_idle();
        check_frame("gapped", 208, 1);

        // Async reset partway through byte 14, then a whole frame.
        @(negedge clk);
        for (int i = 0; i < 14; i++) send_byte(BW'(8'hE0 + i));
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        sb.delete();
        frame_cnt = 0;
        #1;
        chk("midrst_shift_en", int'(shift_en), 0);
        chk("midrst_ser_out", int'(ser_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_latch", int'(latch), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        check_frame("midrst_partial", n_shift, 0);
        @(negedge clk);
        for (int i = 0; i < int'(NB); i++) send_byte(BW'(8'h80 + i));
        wait_idle();
        check_frame("after_rst", 208, 1);

        repeat (3) @(negedge clk);
        chk("end_queue_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
